// File: rtl/axis_elastic_pipeline.sv
// rtl/axis_elastic_pipeline.sv - Parametrised AXI4-Stream elastic buffer with occupancy and packet status
//
// Purpose:
//   Ring of DEPTH register entries holding {tdata, tkeep, tlast, tuser}.
//   The buffer sustains one beat per cycle. s_axis_tready comes only from
//   flops and flush, so the block cuts the combinational ready path between
//   stream stages.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   flush              synchronous discard of all stored beats
//   s_axis_*           upstream stream (tdata/tkeep/tvalid/tready/tlast/tuser)
//   m_axis_*           downstream stream, payload read from entry[rd_ptr]
//   count              beats currently stored
//   pkt_count          stored beats carrying tlast (complete packets held)
//   almost_full        count >= AF_LEVEL
//   overflow_attempt   registered pulse, valid beat refused because full

module axis_elastic_pipeline #(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int LAST_ENABLE = 1,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int DEPTH       = 4,
  parameter int AF_LEVEL    = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]        s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  input  logic [USER_WIDTH-1:0]        s_axis_tuser,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [USER_WIDTH-1:0]        m_axis_tuser,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   pkt_count,
  output logic                         almost_full,
  output logic                         overflow_attempt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [31:0]   AF_U     = 32'(AF_LEVEL);

  if ((DEPTH < 2) || (DEPTH > 256)) begin : g_bad_depth
    $error("axis_elastic_pipeline: DEPTH must be within 2..256");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pkt_count_q, pkt_count_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;
  logic          last_in, last_out;

  // Payload storage carries no reset; validity is tracked by count_q alone.
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  assign s_axis_tready = (count_q != FULL_C) & ~flush;
  assign m_axis_tvalid = (count_q != '0);
  assign push          = s_axis_tvalid & s_axis_tready;
  assign pop           = m_axis_tvalid & m_axis_tready;

  assign count            = count_q;
  assign pkt_count        = pkt_count_q;
  assign almost_full      = (32'(count_q) >= AF_U);
  assign overflow_attempt = ovf_q;

  assign m_axis_tdata = data_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= s_axis_tdata;
    end
  end

  if (KEEP_ENABLE != 0) begin : g_keep
    logic [KEEP_WIDTH-1:0] keep_q [DEPTH];
    always_ff @(posedge clk) begin
      if (push) begin
        keep_q[wr_ptr_q] <= s_axis_tkeep;
      end
    end
    assign m_axis_tkeep = keep_q[rd_ptr_q];
  end else begin : g_no_keep
    logic unused_keep;
    assign unused_keep  = ^s_axis_tkeep;
    assign m_axis_tkeep = '1;
  end

  if (LAST_ENABLE != 0) begin : g_last
    logic last_q [DEPTH];
    always_ff @(posedge clk) begin
      if (push) begin
        last_q[wr_ptr_q] <= s_axis_tlast;
      end
    end
    assign last_in  = s_axis_tlast;
    assign last_out = last_q[rd_ptr_q];
  end else begin : g_no_last
    // Without tlast every beat is its own packet.
    logic unused_last;
    assign unused_last = s_axis_tlast;
    assign last_in     = 1'b1;
    assign last_out    = 1'b1;
  end
  assign m_axis_tlast = last_out;

  if (USER_ENABLE != 0) begin : g_user
    logic [USER_WIDTH-1:0] user_q [DEPTH];
    always_ff @(posedge clk) begin
      if (push) begin
        user_q[wr_ptr_q] <= s_axis_tuser;
      end
    end
    assign m_axis_tuser = user_q[rd_ptr_q];
  end else begin : g_no_user
    logic unused_user;
    assign unused_user  = ^s_axis_tuser;
    assign m_axis_tuser = '0;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pkt_count_d = pkt_count_q;
    // Refusal is only reported when full; flush already forces ready low.
    ovf_d       = s_axis_tvalid & ~flush & (count_q == FULL_C);

    if (flush) begin
      // Flush wins over any push/pop offered in the same cycle.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      pkt_count_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
      end
      count_d     = count_q + CW'(push) - CW'(pop);
      pkt_count_d = pkt_count_q + CW'(push & last_in) - CW'(pop & last_out);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_count_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_count_q <= pkt_count_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_axis_elastic_pipeline.sv
// tb/tb_axis_elastic_pipeline.sv - Directed self-checking bench for axis_elastic_pipeline

module tb_axis_elastic_pipeline;

  logic       clk = 1'b0;
  logic       rstn;
  logic       flush;
  logic [7:0] s_tdata;
  logic [0:0] s_tkeep;
  logic       s_tvalid;
  logic       s_tlast;
  logic [0:0] s_tuser;
  logic       m_tready;

  logic       s4_tready, m4_tvalid, m4_tlast, af4, ovf4;
  logic [7:0] m4_tdata;
  logic [0:0] m4_tkeep, m4_tuser;
  logic [2:0] cnt4, pkt4;

  logic       s3_tready, m3_tvalid, m3_tlast, af3, ovf3;
  logic [7:0] m3_tdata;
  logic [0:0] m3_tkeep, m3_tuser;
  logic [1:0] cnt3, pkt3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axis_elastic_pipeline #(
    .DATA_WIDTH(8), .DEPTH(4)
  ) dut4 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s4_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m4_tdata), .m_axis_tkeep(m4_tkeep), .m_axis_tvalid(m4_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m4_tlast), .m_axis_tuser(m4_tuser),
    .count(cnt4), .pkt_count(pkt4), .almost_full(af4), .overflow_attempt(ovf4)
  );

  axis_elastic_pipeline #(
    .DATA_WIDTH(8), .KEEP_ENABLE(1), .KEEP_WIDTH(1), .LAST_ENABLE(0),
    .USER_ENABLE(0), .DEPTH(3)
  ) dut3 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s3_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m3_tdata), .m_axis_tkeep(m3_tkeep), .m_axis_tvalid(m3_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m3_tlast), .m_axis_tuser(m3_tuser),
    .count(cnt3), .pkt_count(pkt3), .almost_full(af3), .overflow_attempt(ovf3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int  in_idx, out_idx, cyc;
    logic push_e, pop_e;

    rstn = 1'b0; flush = 1'b0; s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0;
    s_tlast = 1'b0; s_tuser = '0; m_tready = 1'b0;
    repeat (2) tick();

    // Reset state
    check_eq("rst_count", cnt4, 0);
    check_eq("rst_pkt", pkt4, 0);
    check_eq("rst_mvalid", m4_tvalid, 0);
    check_eq("rst_sready", s4_tready, 1);
    check_eq("rst_af", af4, 0);
    check_eq("rst_ovf", ovf4, 0);
    rstn = 1'b1;
    tick();

    // Streaming: 16 beats, output always ready
    s_tvalid = 1'b1; m_tready = 1'b1; s_tdata = 8'd0;
    #1;
    check_eq("no_bypass", m4_tvalid, 0);
    for (int i = 0; i < 16; i++) begin
      s_tdata = 8'(i);
      tick();
      check_eq("stream_valid", m4_tvalid, 1);
      check_eq("stream_data", m4_tdata, i);
      check_eq("stream_count", cnt4, 1);
      check_eq("stream_sready", s4_tready, 1);
    end
    s_tvalid = 1'b0;
    tick();
    check_eq("stream_end_count", cnt4, 0);
    check_eq("stream_end_valid", m4_tvalid, 0);

    // Fill and drain
    m_tready = 1'b0; s_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_tdata = 8'(i);
      tick();
      check_eq("fill_count", cnt4, i + 1);
      check_eq("fill_af", af4, (i >= 2) ? 1 : 0);
    end
    check_eq("full_sready", s4_tready, 0);
    s_tdata = 8'd4;
    tick();
    check_eq("ovf_1", ovf4, 1);
    check_eq("full_hold_count", cnt4, 4);
    tick();
    check_eq("ovf_2", ovf4, 1);
    // Pop at full with a beat offered: nothing accepted this edge
    m_tready = 1'b1;
    check_eq("drain_d0", m4_tdata, 0);
    tick();
    check_eq("ovf_3", ovf4, 1);
    check_eq("popfull_count", cnt4, 3);
    check_eq("popfull_sready", s4_tready, 1);
    check_eq("drain_d1", m4_tdata, 1);
    tick();
    check_eq("ovf_clear", ovf4, 0);
    check_eq("drain_cnt_a", cnt4, 3);
    check_eq("drain_d2", m4_tdata, 2);
    s_tdata = 8'd5;
    tick();
    check_eq("drain_cnt_b", cnt4, 3);
    check_eq("drain_d3", m4_tdata, 3);
    s_tvalid = 1'b0;
    tick();
    check_eq("drain_cnt_c", cnt4, 2);
    check_eq("drain_af_low", af4, 0);
    check_eq("drain_d4", m4_tdata, 4);
    tick();
    check_eq("drain_d5", m4_tdata, 5);
    tick();
    check_eq("drain_empty", m4_tvalid, 0);

    // Packets of lengths 1, 2, 1
    m_tready = 1'b0; s_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_tdata = 8'(8'h20 + i);
      s_tlast = (i != 1);
      tick();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    check_eq("pkt_three", pkt4, 3);
    check_eq("pkt_count4", cnt4, 4);
    check_eq("pkt_head", m4_tdata, 8'h20);
    check_eq("pkt_head_last", m4_tlast, 1);
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    check_eq("pkt_two", pkt4, 2);
    check_eq("pkt_cnt3", cnt4, 3);
    check_eq("pkt_next", m4_tdata, 8'h21);
    check_eq("pkt_next_last", m4_tlast, 0);

    // Flush with push and pop offered
    flush = 1'b1; s_tvalid = 1'b1; s_tdata = 8'h77; s_tlast = 1'b1; m_tready = 1'b1;
    #1;
    check_eq("flush_sready", s4_tready, 0);
    tick();
    flush = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
    check_eq("flush_count", cnt4, 0);
    check_eq("flush_pkt", pkt4, 0);
    check_eq("flush_mvalid", m4_tvalid, 0);
    check_eq("flush_ovf", ovf4, 0);
    s_tdata = 8'hA5; s_tlast = 1'b1; s_tuser = 1'b1; s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    check_eq("a5_valid", m4_tvalid, 1);
    check_eq("a5_data", m4_tdata, 8'hA5);
    check_eq("a5_last", m4_tlast, 1);
    check_eq("a5_user", m4_tuser, 1);
    check_eq("a5_keep", m4_tkeep, 1);
    check_eq("a5_count", cnt4, 1);
    check_eq("a5_pkt", pkt4, 1);
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    check_eq("a5_alone", m4_tvalid, 0);
    check_eq("a5_gone", cnt4, 0);

    // Asynchronous reset mid-packet
    s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = 8'h30;
    tick();
    s_tdata = 8'h31;
    tick();
    check_eq("pre_rst_count", cnt4, 2);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("arst_mvalid4", m4_tvalid, 0);
    check_eq("arst_count4", cnt4, 0);
    check_eq("arst_pkt4", pkt4, 0);
    check_eq("arst_sready4", s4_tready, 1);
    check_eq("arst_mvalid3", m3_tvalid, 0);
    check_eq("arst_count3", cnt3, 0);
    s_tvalid = 1'b0;
    #1;
    rstn = 1'b1;
    tick();

    // DEPTH=3 restart: 10 beats, output stalled early then intermittently
    in_idx = 0; out_idx = 0; cyc = 0;
    s_tvalid = 1'b1; s_tdata = 8'h10; s_tkeep = 1'b0;
    while ((out_idx < 10) && (cyc < 40)) begin
      m_tready = (cyc >= 4) && ((cyc % 4) != 3);
      #1;
      check_eq("d3_valid", m3_tvalid, (in_idx != out_idx) ? 1 : 0);
      if (in_idx != out_idx) begin
        check_eq("d3_data", m3_tdata, 8'(8'h10 + out_idx));
        check_eq("d3_keep", m3_tkeep, out_idx & 1);
        check_eq("d3_last", m3_tlast, 1);
        check_eq("d3_user", m3_tuser, 0);
      end
      if ((in_idx - out_idx) == 3) begin
        check_eq("d3_full_sready", s3_tready, 0);
      end
      push_e = s_tvalid && s3_tready;
      pop_e  = m3_tvalid && m_tready;
      tick();
      if (push_e) in_idx++;
      if (pop_e) out_idx++;
      s_tvalid = (in_idx < 10);
      s_tdata  = 8'(8'h10 + in_idx);
      s_tkeep  = 1'(in_idx & 1);
      check_eq("d3_count", cnt3, in_idx - out_idx);
      check_eq("d3_pkt", pkt3, in_idx - out_idx);
      cyc++;
    end
    s_tvalid = 1'b0; m_tready = 1'b0;
    check_eq("d3_all_out", out_idx, 10);
    check_eq("d3_empty", m3_tvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
